uart_req_arbiter: RTL and testbench

Round-robin arbiter and transaction sequencer that shares a single loopback UART core (TX/RX pair with common enable/start/busy/done) between NUM_REQ byte requesters. It grants one requester at a time, drives the UART start handshake, waits for frame completion or a timeout, and returns the looped-back byte and status to the granted requester. It sits between the APB-side register/requester logic and the UART core.

---
 rtl/uart_req_arbiter.sv | 137 +++++++++++++
 tb/tb_uart_req_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_req_arbiter.sv
// Round-robin arbiter sharing one loopback UART among NUM_REQ byte requesters: grants one,
// drives the start handshake, waits for done or timeout, and returns the byte with status flags.
module uart_req_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ack,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [7:0]                 rsp_data,
  output logic                       rsp_error,
  output logic                       rsp_timeout,
  output logic                       rsp_mismatch,
  output logic                       arb_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       uart_enable,
  output logic                       uart_start,
  output logic [7:0]                 uart_data_in,
  input  logic [7:0]                 uart_data_out,
  input  logic                       uart_busy,
  input  logic                       uart_done,
  input  logic                       uart_error
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE, RESP} state_t;

  state_t         state;
  logic [IDW-1:0] last_grant;
  logic [CW-1:0]  cnt;
  logic [7:0]     tx_byte;
  logic [IDW-1:0] pick;
  logic [7:0]     pick_byte;
  logic           unused_busy;

  // First requesting index strictly after 'last', wrapping at NUM_REQ-1 back to 0.
  function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                             input logic [IDW-1:0]     last);
    logic [IDW-1:0] sel;
    logic [IDW-1:0] idx;
    sel = last;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = IDW'((int'(last) + i) % NUM_REQ);
      if (valid[idx]) sel = idx;
    end
    return sel;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDW-1:0] id);
    logic [NUM_REQ-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  always_comb begin
    pick      = rr_pick(req_valid, last_grant);
    pick_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == IDW'(i)) pick_byte = req_data[8*i +: 8];
    end
  end

  assign uart_data_in = tx_byte;
  assign arb_busy     = (state != IDLE);
  assign unused_busy  = uart_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      last_grant   <= IDW'(NUM_REQ - 1);
      grant_id     <= '0;
      tx_byte      <= '0;
      cnt          <= '0;
      req_ack      <= '0;
      rsp_valid    <= '0;
      uart_start   <= 1'b0;
      uart_enable  <= 1'b0;
      rsp_data     <= '0;
      rsp_error    <= 1'b0;
      rsp_timeout  <= 1'b0;
      rsp_mismatch <= 1'b0;
    end else begin
      req_ack    <= '0;
      rsp_valid  <= '0;
      uart_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|req_valid) begin
            grant_id    <= pick;
            tx_byte     <= pick_byte;
            req_ack     <= onehot(pick);
            uart_start  <= 1'b1;
            uart_enable <= 1'b1;
            state       <= START;
          end
        end
        START: begin
          cnt   <= '0;
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          // Completion takes priority over the terminal count on the same cycle.
          if (uart_done) begin
            rsp_data     <= uart_data_out;
            rsp_error    <= uart_error;
            rsp_mismatch <= (uart_data_out != tx_byte);
            rsp_timeout  <= 1'b0;
            rsp_valid    <= onehot(grant_id);
            uart_enable  <= 1'b0;
            state        <= RESP;
          end else if (cnt == TERM) begin
            rsp_data     <= '0;
            rsp_error    <= 1'b0;
            rsp_mismatch <= 1'b0;
            rsp_timeout  <= 1'b1;
            rsp_valid    <= onehot(grant_id);
            uart_enable  <= 1'b0;
            state        <= RESP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP: begin
          last_grant <= grant_id;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_req_arbiter.sv
// Scoreboard bench for uart_req_arbiter with a simple loopback UART model driven from tasks.
module tb_uart_req_arbiter;
  localparam int NUM_REQ = 4;
  localparam int TMO     = 50;

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
    logic       err;
    logic       tmo;
    logic       mis;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ack;
  logic [3:0]  rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_error, rsp_timeout, rsp_mismatch, arb_busy;
  logic [1:0]  grant_id;
  logic        uart_enable, uart_start;
  logic [7:0]  uart_data_in, uart_data_out;
  logic        uart_busy, uart_done, uart_error;

  uart_req_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_error(rsp_error), .rsp_timeout(rsp_timeout), .rsp_mismatch(rsp_mismatch),
    .arb_busy(arb_busy), .grant_id(grant_id), .uart_enable(uart_enable),
    .uart_start(uart_start), .uart_data_in(uart_data_in), .uart_data_out(uart_data_out),
    .uart_busy(uart_busy), .uart_done(uart_done), .uart_error(uart_error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(output bit got);
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (uart_start === 1'b1) begin
        got = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_rsp(output int cyc, output bit got);
    got = 1'b0;
    cyc = 0;
    for (int i = 0; i < 200; i++) begin
      if (|rsp_valid) begin
        got = 1'b1;
        break;
      end
      tick();
      cyc++;
    end
  endtask

  task automatic uart_finish(input int delay, input logic [7:0] rx, input logic err);
    repeat (delay) tick();
    uart_done     = 1'b1;
    uart_data_out = rx;
    uart_error    = err;
    tick();
    uart_done  = 1'b0;
    uart_error = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    checks++;
    if ({req_ack, rsp_valid, uart_start, uart_enable, arb_busy} !== 11'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got %h expected 0", {req_ack, rsp_valid, uart_start, uart_enable, arb_busy});
    end
    checks++;
    if ({grant_id, rsp_data, rsp_error, rsp_timeout, rsp_mismatch, uart_data_in} !== 21'd0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0",
               {grant_id, rsp_data, rsp_error, rsp_timeout, rsp_mismatch, uart_data_in});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    exp_t e;
    bit   got;
    int   cyc;
    req_data  = 32'h00A5_0000;
    req_valid = 4'b0100;
    tick();
    checks++;
    if ({req_ack, uart_start, grant_id, uart_data_in} !== {4'b0100, 1'b1, 2'd2, 8'hA5}) begin
      errors++;
      $display("FAIL single_grant: got %h expected %h",
               {req_ack, uart_start, grant_id, uart_data_in}, {4'b0100, 1'b1, 2'd2, 8'hA5});
    end
    sb.push_back('{2'd2, 8'hA5, 1'b0, 1'b0, 1'b0});
    req_valid = 4'b0000;
    tick();
    checks++;
    if ({uart_start, req_ack, uart_enable} !== 6'b000001) begin
      errors++;
      $display("FAIL single_pulse: got %b expected 000001", {uart_start, req_ack, uart_enable});
    end
    uart_finish(19, 8'hA5, 1'b0);
    wait_rsp(cyc, got);
    checks++;
    e = sb.pop_front();
    if (!got || {rsp_valid, rsp_data, rsp_error, rsp_timeout, rsp_mismatch} !==
                {4'b0001 << e.id, e.data, e.err, e.tmo, e.mis}) begin
      errors++;
      $display("FAIL single_rsp: got %h expected %h (seen=%0d)",
               {rsp_valid, rsp_data, rsp_error, rsp_timeout, rsp_mismatch},
               {4'b0001 << e.id, e.data, e.err, e.tmo, e.mis}, got);
    end
    tick();
    checks++;
    if ({rsp_valid, arb_busy, uart_enable, rsp_data} !== {4'b0000, 1'b0, 1'b0, 8'hA5}) begin
      errors++;
      $display("FAIL single_idle: got %h expected %h",
               {rsp_valid, arb_busy, uart_enable, rsp_data}, {4'b0000, 1'b0, 1'b0, 8'hA5});
    end
  endtask

  task automatic test_fairness();
    exp_t e;
    bit   got;
    int   cyc;
    int   prev;
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    prev      = -1;
    req_data  = 32'h1312_1110;
    req_valid = 4'b1111;
    for (int t = 0; t < 8; t++) begin
      wait_start(got);
      checks++;
      if (!got || grant_id !== 2'(t % 4) || uart_data_in !== 8'(16 + t % 4)) begin
        errors++;
        $display("FAIL fair_grant%0d: got id=%0d byte=%h expected id=%0d byte=%h (seen=%0d)",
                 t, grant_id, uart_data_in, t % 4, 8'(16 + t % 4), got);
      end
      checks++;
      if (int'(grant_id) == prev) begin
        errors++;
        $display("FAIL fair_repeat%0d: got id=%0d expected not %0d", t, grant_id, prev);
      end
      prev = int'(grant_id);
      sb.push_back('{2'(t % 4), 8'(16 + t % 4), 1'b0, 1'b0, 1'b0});
      uart_finish(2, 8'(16 + t % 4), 1'b0);
      wait_rsp(cyc, got);
      checks++;
      e = sb.pop_front();
      if (!got || {rsp_valid, rsp_data, rsp_error, rsp_timeout, rsp_mismatch} !==
                  {4'b0001 << e.id, e.data, e.err, e.tmo, e.mis}) begin
        errors++;
        $display("FAIL fair_rsp%0d: got %h expected %h (seen=%0d)", t,
                 {rsp_valid, rsp_data, rsp_error, rsp_timeout, rsp_mismatch},
                 {4'b0001 << e.id, e.data, e.err, e.tmo, e.mis}, got);
      end
      if (t == 7) req_valid = 4'b0000;
    end
    repeat (2) tick();
  endtask

  task automatic test_mismatch_error();
    exp_t e;
    bit   got;
    int   cyc;
    req_data  = 32'h0000_3C00;
    req_valid = 4'b0010;
    wait_start(got);
    req_valid = 4'b0000;
    sb.push_back('{2'd1, 8'h3D, 1'b1, 1'b0, 1'b1});
    uart_finish(5, 8'h3D, 1'b1);
    wait_rsp(cyc, got);
    checks++;
    e = sb.pop_front();
    if (!got || {rsp_valid, rsp_data, rsp_error, rsp_timeout, rsp_mismatch} !==
                {4'b0001 << e.id, e.data, e.err, e.tmo, e.mis}) begin
      errors++;
      $display("FAIL mismatch_rsp: got %h expected %h (seen=%0d)",
               {rsp_valid, rsp_data, rsp_error, rsp_timeout, rsp_mismatch},
               {4'b0001 << e.id, e.data, e.err, e.tmo, e.mis}, got);
    end
    repeat (2) tick();
  endtask

  task automatic test_timeout();
    exp_t e;
    bit   got;
    int   cyc;
    req_data  = 32'h5A00_0077;
    req_valid = 4'b0001;
    wait_start(got);
    req_valid = 4'b0000;
    sb.push_back('{2'd0, 8'h00, 1'b0, 1'b1, 1'b0});
    wait_rsp(cyc, got);
    checks++;
    if (!got || cyc != TMO + 1) begin
      errors++;
      $display("FAIL timeout_latency: got %0d cycles expected %0d (seen=%0d)", cyc, TMO + 1, got);
    end
    checks++;
    e = sb.pop_front();
    if ({rsp_valid, rsp_data, rsp_error, rsp_timeout, rsp_mismatch} !==
        {4'b0001 << e.id, e.data, e.err, e.tmo, e.mis}) begin
      errors++;
      $display("FAIL timeout_rsp: got %h expected %h",
               {rsp_valid, rsp_data, rsp_error, rsp_timeout, rsp_mismatch},
               {4'b0001 << e.id, e.data, e.err, e.tmo, e.mis});
    end
    req_valid = 4'b1000;
    wait_start(got);
    checks++;
    if (!got || grant_id !== 2'd3 || uart_data_in !== 8'h5A) begin
      errors++;
      $display("FAIL after_timeout_grant: got id=%0d byte=%h expected id=3 byte=5a (seen=%0d)",
               grant_id, uart_data_in, got);
    end
    req_valid = 4'b0000;
    sb.push_back('{2'd3, 8'h5A, 1'b0, 1'b0, 1'b0});
    uart_finish(3, 8'h5A, 1'b0);
    wait_rsp(cyc, got);
    checks++;
    e = sb.pop_front();
    if (!got || {rsp_valid, rsp_data, rsp_error, rsp_timeout, rsp_mismatch} !==
                {4'b0001 << e.id, e.data, e.err, e.tmo, e.mis}) begin
      errors++;
      $display("FAIL after_timeout_rsp: got %h expected %h (seen=%0d)",
               {rsp_valid, rsp_data, rsp_error, rsp_timeout, rsp_mismatch},
               {4'b0001 << e.id, e.data, e.err, e.tmo, e.mis}, got);
    end
    repeat (2) tick();
  endtask

  task automatic test_boundary();
    exp_t e;
    bit   got;
    int   cyc;
    req_data  = 32'h0000_8100;
    req_valid = 4'b0010;
    wait_start(got);
    req_valid = 4'b0000;
    sb.push_back('{2'd1, 8'h81, 1'b0, 1'b0, 1'b0});
    // Done arrives on the edge where the counter sits at its terminal value.
    uart_finish(TMO, 8'h81, 1'b0);
    wait_rsp(cyc, got);
    checks++;
    e = sb.pop_front();
    if (!got || cyc != 0 || {rsp_valid, rsp_data, rsp_error, rsp_timeout, rsp_mismatch} !==
                            {4'b0001 << e.id, e.data, e.err, e.tmo, e.mis}) begin
      errors++;
      $display("FAIL terminal_done_rsp: got %h after %0d expected %h after 0 (seen=%0d)",
               {rsp_valid, rsp_data, rsp_error, rsp_timeout, rsp_mismatch}, cyc,
               {4'b0001 << e.id, e.data, e.err, e.tmo, e.mis}, got);
    end
    tick();
    uart_done     = 1'b1;
    uart_data_out = 8'hFF;
    uart_error    = 1'b1;
    tick();
    uart_done  = 1'b0;
    uart_error = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({rsp_valid, arb_busy, rsp_data, rsp_error} !== {4'b0000, 1'b0, 8'h81, 1'b0}) begin
        errors++;
        $display("FAIL stray_done%0d: got %h expected %h", i,
                 {rsp_valid, arb_busy, rsp_data, rsp_error}, {4'b0000, 1'b0, 8'h81, 1'b0});
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bit   got;
    int   cyc;
    req_data  = 32'h0044_0000;
    req_valid = 4'b0100;
    wait_start(got);
    req_valid = 4'b0000;
    repeat (3) tick();
    checks++;
    if (uart_enable !== 1'b1) begin
      errors++;
      $display("FAIL mid_enable: got %b expected 1", uart_enable);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({uart_enable, arb_busy, rsp_valid} !== 6'd0) begin
      errors++;
      $display("FAIL mid_reset_async: got %b expected 000000", {uart_enable, arb_busy, rsp_valid});
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (rsp_valid !== 4'b0000) begin
        errors++;
        $display("FAIL mid_no_rsp%0d: got %b expected 0000", i, rsp_valid);
      end
    end
    req_data  = 32'h4433_2211;
    req_valid = 4'b1111;
    wait_start(got);
    checks++;
    if (!got || grant_id !== 2'd0 || uart_data_in !== 8'h11) begin
      errors++;
      $display("FAIL post_reset_grant: got id=%0d byte=%h expected id=0 byte=11 (seen=%0d)",
               grant_id, uart_data_in, got);
    end
    req_valid = 4'b0000;
    sb.push_back('{2'd0, 8'h11, 1'b0, 1'b0, 1'b0});
    uart_finish(4, 8'h11, 1'b0);
    wait_rsp(cyc, got);
    checks++;
    e = sb.pop_front();
    if (!got || {rsp_valid, rsp_data, rsp_error, rsp_timeout, rsp_mismatch} !==
                {4'b0001 << e.id, e.data, e.err, e.tmo, e.mis}) begin
      errors++;
      $display("FAIL post_reset_rsp: got %h expected %h (seen=%0d)",
               {rsp_valid, rsp_data, rsp_error, rsp_timeout, rsp_mismatch},
               {4'b0001 << e.id, e.data, e.err, e.tmo, e.mis}, got);
    end
    repeat (2) tick();
  endtask

  initial begin
    reset         = 1'b1;
    req_valid     = '0;
    req_data      = '0;
    uart_data_out = '0;
    uart_busy     = 1'b0;
    uart_done     = 1'b0;
    uart_error    = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_mismatch_error();
    test_timeout();
    test_boundary();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
